// File: rtl/vm_pkg.sv
// vm_pkg: shared coin encodings, coin values and dispenser state encoding
package vm_pkg;
    localparam logic [2:0] COIN_NONE = 3'b000;
    localparam logic [2:0] COIN_1    = 3'b001;
    localparam logic [2:0] COIN_2    = 3'b010;
    localparam logic [2:0] COIN_5    = 3'b011;
    localparam logic [2:0] COIN_10   = 3'b100;
    localparam int VAL_1  = 1;
    localparam int VAL_2  = 2;
    localparam int VAL_5  = 5;
    localparam int VAL_10 = 10;
    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PAY,
        S_DONE,
        S_FAULT
    } disp_state_t;
endpackage

// File: rtl/coin_selector.sv
// coin_selector: largest stocked coin not exceeding the amount still owed
module coin_selector
    import vm_pkg::*;
#(
    parameter int AMT_W = 5
) (
    input  logic [AMT_W-1:0] remaining,
    input  logic [3:0]       empty,
    output logic [2:0]       code,
    output logic [AMT_W-1:0] value,
    output logic             found
);
    logic ok10, ok5, ok2, ok1;
    always_comb begin
        ok10  = !empty[3] && remaining >= AMT_W'(VAL_10);
        ok5   = !empty[2] && remaining >= AMT_W'(VAL_5);
        ok2   = !empty[1] && remaining >= AMT_W'(VAL_2);
        ok1   = !empty[0] && remaining >= AMT_W'(VAL_1);
        found = ok10 || ok5 || ok2 || ok1;
        code  = ok10 ? COIN_10 : ok5 ? COIN_5 : ok2 ? COIN_2 : ok1 ? COIN_1 : COIN_NONE;
        value = ok10 ? AMT_W'(VAL_10) : ok5 ? AMT_W'(VAL_5) : ok2 ? AMT_W'(VAL_2) :
                ok1 ? AMT_W'(VAL_1) : '0;
    end
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: breaks a change amount into coins and hands them to the hopper one at a time
module change_dispenser
    import vm_pkg::*;
#(
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             change_valid,
    input  logic [AMT_W-1:0] change_amt,
    input  logic [3:0]       empty,
    input  logic             coin_ack,
    input  logic             clear,
    output logic [2:0]       coin_out,
    output logic             coin_valid,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] remaining
);
    disp_state_t      state;
    logic [AMT_W-1:0] coin_val;
    logic [2:0]       sel_code;
    logic [AMT_W-1:0] sel_val;
    logic             sel_found;

    coin_selector #(.AMT_W(AMT_W)) u_sel (
        .remaining(remaining),
        .empty    (empty),
        .code     (sel_code),
        .value    (sel_val),
        .found    (sel_found)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            coin_out   <= COIN_NONE;
            coin_val   <= '0;
            coin_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            remaining  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (change_valid) begin
                    busy <= 1'b1;
                    if (change_amt != '0) begin
                        remaining <= change_amt;
                        state     <= S_SELECT;
                    end else begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_SELECT: if (sel_found) begin
                    coin_out   <= sel_code;
                    coin_val   <= sel_val;
                    coin_valid <= 1'b1;
                    state      <= S_PAY;
                end else begin
                    fault <= 1'b1;
                    state <= S_FAULT;
                end
                // the offered coin stays put until acked, whatever empty does meanwhile
                S_PAY: if (coin_ack) begin
                    coin_out   <= COIN_NONE;
                    coin_valid <= 1'b0;
                    remaining  <= remaining - coin_val;
                    done       <= remaining == coin_val;
                    state      <= remaining == coin_val ? S_DONE : S_SELECT;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_FAULT: if (clear) begin
                    fault     <= 1'b0;
                    busy      <= 1'b0;
                    remaining <= '0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: table-driven payouts plus hand-written reset/stall/ignore sequences
module tb_change_dispenser;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       change_valid = 1'b0;
    logic [4:0] change_amt = '0;
    logic [3:0] empty = '0;
    logic       coin_ack = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] coin_out;
    logic       coin_valid, busy, done, fault;
    logic [4:0] remaining;

    int tests = 0;
    int fails = 0;

    change_dispenser #(.AMT_W(5)) dut (
        .clk(clk), .rst(rst), .change_valid(change_valid), .change_amt(change_amt),
        .empty(empty), .coin_ack(coin_ack), .clear(clear), .coin_out(coin_out),
        .coin_valid(coin_valid), .busy(busy), .done(done), .fault(fault), .remaining(remaining)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  amt;
        logic [3:0]  empty;
        int          delay;
        logic [23:0] coins;
        int          n;
        logic        flt;
        logic [4:0]  rem;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int cval(input logic [2:0] c);
        case (c)
            3'b001:  return 1;
            3'b010:  return 2;
            3'b011:  return 5;
            3'b100:  return 10;
            default: return 0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_coin_out"}, coin_out, 0);
        chk({tag, "_coin_valid"}, coin_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_fault"}, fault, 0);
        chk({tag, "_remaining"}, remaining, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int got = 0;
        int cyc = 0;
        int rem = int'(v.amt);
        bit fin = 0;
        logic [2:0] exp;
        tick();
        change_amt = v.amt;
        empty = v.empty;
        change_valid = 1'b1;
        tick();
        change_valid = 1'b0;
        if (v.amt == 0) chk("zero_done_now", done, 1);
        while (!fin && cyc < 200) begin
            if (done || fault) begin
                fin = 1;
            end else if (coin_valid) begin
                exp = got < 8 ? v.coins[3*got +: 3] : 3'b000;
                chk("coin_code", coin_out, exp);
                repeat (v.delay) begin
                    tick();
                    chk("hold_valid", coin_valid, 1);
                    chk("hold_coin", coin_out, exp);
                end
                coin_ack = 1'b1;
                tick();
                coin_ack = 1'b0;
                rem -= cval(exp);
                got++;
                chk("rem_step", remaining, rem);
                chk("valid_drop", coin_valid, 0);
                if (got == v.n && !v.flt) chk("done_timing", done, 1);
            end else begin
                chk("busy_mid", busy, 1);
                tick();
            end
            cyc++;
        end
        if (!fin) chk("payout_timeout", 0, 1);
        chk("coin_count", got, v.n);
        chk("fault_end", fault, v.flt);
        chk("rem_end", remaining, v.rem);
        if (fin && !v.flt) begin
            tick();
            chk("done_one_cycle", done, 0);
            chk("busy_fall", busy, 0);
        end
        if (fin && v.flt) begin
            tick();
            chk("fault_hold", fault, 1);
            clear = 1'b1;
            tick();
            clear = 1'b0;
            chk("clear_fault", fault, 0);
            chk("clear_rem", remaining, 0);
            chk("clear_busy", busy, 0);
        end
        empty = '0;
    endtask

    task automatic wait_valid(input string name);
        int c = 0;
        while (!coin_valid && c < 50) begin
            tick();
            c++;
        end
        if (!coin_valid) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        vt[0] = '{5'd5,  4'b0000, 0, {21'b0, 3'b011}, 1, 1'b0, 5'd0};
        vt[1] = '{5'd18, 4'b0000, 0, {12'b0, 3'b001, 3'b010, 3'b011, 3'b100}, 4, 1'b0, 5'd0};
        vt[2] = '{5'd8,  4'b0100, 0, {12'b0, 3'b010, 3'b010, 3'b010, 3'b010}, 4, 1'b0, 5'd0};
        vt[3] = '{5'd3,  4'b0001, 0, {21'b0, 3'b010}, 1, 1'b1, 5'd1};
        vt[4] = '{5'd10, 4'b0000, 3, {21'b0, 3'b100}, 1, 1'b0, 5'd0};
        vt[5] = '{5'd0,  4'b0000, 0, 24'b0, 0, 1'b0, 5'd0};
        vt[6] = '{5'd31, 4'b0000, 1, {12'b0, 3'b001, 3'b100, 3'b100, 3'b100}, 4, 1'b0, 5'd0};
        vt[7] = '{5'd7,  4'b1111, 0, 24'b0, 0, 1'b1, 5'd7};
        vt[8] = '{5'd9,  4'b1010, 0, {9'b0, 3'b001, 3'b001, 3'b001, 3'b001, 3'b011}, 5, 1'b0, 5'd0};

        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vt[i]);

        // ack and clear while idle must do nothing
        coin_ack = 1'b1;
        clear = 1'b1;
        tick();
        tick();
        coin_ack = 1'b0;
        clear = 1'b0;
        chk_reset_outputs("idle_ignore");

        // second request and an empty change while a coin is offered
        change_amt = 5'd10;
        change_valid = 1'b1;
        tick();
        change_valid = 1'b0;
        wait_valid("pay_wait");
        change_amt = 5'd5;
        change_valid = 1'b1;
        empty = 4'b1111;
        tick();
        tick();
        change_valid = 1'b0;
        chk("pay_keep_coin", coin_out, 3'b100);
        chk("pay_keep_valid", coin_valid, 1);
        chk("pay_keep_rem", remaining, 10);
        empty = '0;
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        chk("pay_done", done, 1);
        chk("pay_rem0", remaining, 0);
        tick();
        tick();
        chk("pay_no_queue", busy, 0);

        // reset after the first coin of an 18 payout
        change_amt = 5'd18;
        change_valid = 1'b1;
        tick();
        change_valid = 1'b0;
        wait_valid("rst_wait");
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        chk("rst_mid_rem", remaining, 8);
        rst = 1'b0;
        tick();
        chk_reset_outputs("mid_reset");
        rst = 1'b1;
        tick();
        chk_reset_outputs("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
